digio_pad_arbiter: RTL
======================

# digio_pad_arbiter

Sequencer and arbiter for one bidirectional digital IO pad (the DIGIO pad cell). It shares the pad's output driver between two on-chip requesters. It inserts guaranteed turnaround gaps so that two drivers never meet. It manages the pull and drive-strength controls, and delivers a synchronized input sample whenever the pad is released. It sits between the core logic and the pad ring: its `pad_*` outputs connect straight to the pad cell pins.

## Interface
- `TURN_CYC`, 2: idle cycles with the driver off before a drive and after a release; 0 is legal.
- `SYNC_STAGES`, 2: flip-flop depth of the input synchronizer on `pad_Z`; minimum 2.

Ports:
- `DCLK_1` input 1: block clock; every flop is on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input 2: per-requester drive request. Level-sensitive; the requester holds it for the whole ownership.
- `req_dout` input 2: per-requester data to drive.
- `grant` output 2: one-hot ownership; high only while the pad is actually driven for that requester.
- `cfg_ds` input 1: drive strength applied while driving.
- `cfg_pull_en` input 1: pull enable applied while the pad is idle.
- `cfg_pull_up` input 1: pull direction while idle; 1 = up.
- `pad_A` output 1: pad driver data.
- `pad_OEN` output 1: pad driver enable. In this pad library, 1 = driving.
- `pad_DS` output 1: pad drive strength.
- `pad_PEN` output 1: pad pull enable.
- `pad_UD` output 1: pad pull select.
- `pad_Z` input 1: pad receiver output.
- `din_sync` output 1: synchronized `pad_Z`.
- `rx_valid` output 1: `din_sync` reflects an externally driven pad.
- `loopback_err` output 1: sticky drive/readback mismatch (see Configuration).
- `err_clr` input 1: synchronous clear for `loopback_err`.

## Operation
- FSM states: IDLE, TURN_ON, DRIVE, TURN_OFF.
- **IDLE**
  - Pad outputs: `pad_OEN`=0, `pad_DS`=0, `pad_PEN`=`cfg_pull_en`, `pad_UD`=`cfg_pull_up`.
  - If any `req` is high, pick the winner and go to TURN_ON, or to DRIVE directly when `TURN_CYC`=0.
- **Arbitration**: round-robin over two requesters. On a simultaneous request, the requester that was not the last owner wins. After reset the last-owner pointer is 1, so requester 0 wins the first tie. The pointer updates on entry to DRIVE.
- **TURN_ON**
  - Pad outputs: `pad_OEN`=0, `pad_PEN`=0.
  - Counts `TURN_CYC` cycles, then goes to DRIVE.
  - If the selected requester drops `req`, abort to IDLE with no drive.
- **DRIVE**
  - Pad outputs: `pad_OEN`=1, `pad_PEN`=0, `pad_DS`=`cfg_ds`, `pad_A`=`req_dout[owner]` (registered).
  - `grant[owner]`=1.
  - When the owner drops `req`, go to TURN_OFF. The other requester is ignored until then; there is no pre-emption.
- **TURN_OFF**
  - Pad outputs: `pad_OEN`=0, `pad_PEN`=0, `grant`=0.
  - Counts `TURN_CYC` cycles, then always returns to IDLE, even with a pending `req`. That request is arbitrated in IDLE.
- **Turnaround counter**: width `$clog2(TURN_CYC+1)`, minimum 1 bit. Loaded on state entry; no wrap.
- **Input path**
  - `din_sync` is `pad_Z` through `SYNC_STAGES` flops and always runs.
  - `rx_valid`=1 only after at least `SYNC_STAGES` consecutive cycles in IDLE. It drops in the same cycle IDLE is left.
- **Reset (asynchronous, including mid-drive)**
  - State IDLE, `pad_OEN`=0, `pad_A`=0, `pad_DS`=0, `pad_PEN`=1, `pad_UD`=0.
  - `grant`=0, `din_sync`=0, `rx_valid`=0, `loopback_err`=0.
  - After reset, `pad_PEN` and `pad_UD` follow the cfg inputs from the first IDLE clock.

## Timing
- All pad-side outputs are registered; there is no combinational path from `req` or `cfg_*` to a pad pin.
- Request to drive:
  - `req` seen high at edge n in IDLE: TURN_ON from n+1.
  - DRIVE with `grant` and `pad_OEN` high from n+1+`TURN_CYC`.
  - With `TURN_CYC`=0, DRIVE starts at n+1.
- Data in DRIVE: `req_dout` sampled at edge k appears on `pad_A` after edge k. Latency is 1 cycle.
- Release: `req` low at edge m in DRIVE means `grant`=0 and `pad_OEN`=0 from m+1, followed by `TURN_CYC` TURN_OFF cycles, then IDLE.
- Minimum gap between two owners' drive windows: 2·`TURN_CYC`+1 cycles.

## Configuration
- `DIGIO_LOOPBACK_CHECK_EN`, when defined:
  - In DRIVE, `din_sync` is compared with `pad_A` delayed by `SYNC_STAGES` cycles.
  - The compare is masked during the first `SYNC_STAGES` cycles of each DRIVE.
  - A mismatch sets `loopback_err`, which stays set until `err_clr` or `rst`. If `err_clr` and a new mismatch occur in the same cycle, set wins.
- When not defined: `loopback_err` is tied to 0, `err_clr` is ignored, and there is no compare logic.

## Structure
- Package `digio_pad_pkg`: the FSM state enum, the default `TURN_CYC`/`SYNC_STAGES` constants, and the requester-count constant (2).
- Sub-module `digio_sync`: parameterized `SYNC_STAGES` synchronizer with asynchronous reset to 0. It is instantiated once for `pad_Z`.

## Test plan
- Reset mid-DRIVE with `pad_OEN`=1: assert `rst` between edges → `pad_OEN`=0, `pad_PEN`=1, `grant`=00 immediately, before the next edge.
- `TURN_CYC`=2, `req`=01 at edge 10 → TURN_ON at edges 11–12; `grant`=01, `pad_OEN`=1, `pad_PEN`=0 at edge 13. Drop at 20 → `pad_OEN`=0 at 21, IDLE at 23.
- `req`=11 in the first cycle after reset → requester 0 wins. Release, keep `req[1]` high → requester 1 drives, earliest 5 cycles after requester 0's last driven cycle.
- `TURN_CYC`=0: `req[1]` rises at edge 5 → `grant`=10 at edge 6. Pulse `req[1]` for one cycle during TURN_ON with `TURN_CYC`=3 → abort to IDLE, `pad_OEN` never 1.
- Idle, `cfg_pull_en`=1, `cfg_pull_up`=1, external `pad_Z` toggles → `pad_PEN`=1, `pad_UD`=1, `rx_valid` high after 2 IDLE cycles, `din_sync` follows with 2-cycle lag.
- With `DIGIO_LOOPBACK_CHECK_EN` defined: force `pad_Z`=0 while driving `req_dout`=1 → `loopback_err`=1, sticky through release. Pulse `err_clr` → 0.

Source files
------------

// File: rtl/digio_pad_pkg.sv
// Shared types and defaults for the DIGIO pad arbiter: FSM state encoding,
// default turnaround/synchronizer depths and the requester count.
package digio_pad_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_TURN_ON  = 2'd1,
        S_DRIVE    = 2'd2,
        S_TURN_OFF = 2'd3
    } state_e;

    localparam int TURN_CYC_DEF    = 2;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int NUM_REQ         = 2;

endpackage

// File: rtl/digio_pad_arbiter_sync.sv
// Multi-flop synchronizer (SYNC_STAGES deep, async reset to 0) used for the
// pad receiver output.
module digio_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/digio_pad_arbiter.sv
// Two-requester round-robin owner of one bidirectional DIGIO pad, with
// turnaround gaps, pull/strength control and a synchronized receive path.
// Optional drive/readback compare enabled by DIGIO_LOOPBACK_CHECK_EN.
module digio_pad_arbiter
    import digio_pad_pkg::*;
#(
    parameter int TURN_CYC    = TURN_CYC_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic               DCLK_1,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_dout,
    output logic [NUM_REQ-1:0] grant,
    input  logic               cfg_ds,
    input  logic               cfg_pull_en,
    input  logic               cfg_pull_up,
    output logic               pad_A,
    output logic               pad_OEN,
    output logic               pad_DS,
    output logic               pad_PEN,
    output logic               pad_UD,
    input  logic               pad_Z,
    output logic               din_sync,
    output logic               rx_valid,
    output logic               loopback_err,
    input  logic               err_clr
);

    localparam int CW = (TURN_CYC > 0) ? $clog2(TURN_CYC + 1) : 1;
    localparam int IW = $clog2(SYNC_STAGES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);
    localparam logic [IW-1:0] IDLE_SAT = IW'(SYNC_STAGES);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 owner_q, owner_d;
    logic                 last_q, last_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 pad_a_q, pad_a_d;
    logic                 pad_oen_q, pad_oen_d;
    logic                 pad_ds_q, pad_ds_d;
    logic                 pad_pen_q, pad_pen_d;
    logic                 pad_ud_q, pad_ud_d;
    logic [IW-1:0]        idle_cnt_q, idle_cnt_d;
    logic                 rx_valid_q, rx_valid_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    owner_d = (&req) ? ~last_q : req[1];
                    if (TURN_CYC == 0) begin
                        state_d = S_DRIVE;
                    end else begin
                        state_d = S_TURN_ON;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            S_TURN_ON: begin
                if (!req[owner_q])      state_d = S_IDLE;
                else if (cnt_q == '0)   state_d = S_DRIVE;
                else                    cnt_d   = cnt_q - 1'b1;
            end
            S_DRIVE: begin
                // No pre-emption: only the owner's release ends the window.
                if (!req[owner_q]) begin
                    if (TURN_CYC == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_TURN_OFF;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            S_TURN_OFF: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_DRIVE && state_q != S_DRIVE) last_d = owner_d;

        // Pad pins are registered from the next state so they line up with state_q.
        grant_d   = '0;
        pad_a_d   = 1'b0;
        pad_oen_d = 1'b0;
        pad_ds_d  = 1'b0;
        pad_pen_d = 1'b0;
        pad_ud_d  = pad_ud_q;
        if (state_d == S_DRIVE) begin
            grant_d[owner_d] = 1'b1;
            pad_a_d          = req_dout[owner_d];
            pad_oen_d        = 1'b1;
            pad_ds_d         = cfg_ds;
        end
        if (state_d == S_IDLE) begin
            pad_pen_d = cfg_pull_en;
            pad_ud_d  = cfg_pull_up;
        end

        idle_cnt_d = '0;
        if (state_d == S_IDLE)
            idle_cnt_d = (idle_cnt_q == IDLE_SAT) ? idle_cnt_q : idle_cnt_q + 1'b1;
        rx_valid_d = (state_d == S_IDLE) && (idle_cnt_q == IDLE_SAT);
    end

    always_ff @(posedge DCLK_1 or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            grant_q    <= '0;
            pad_a_q    <= 1'b0;
            pad_oen_q  <= 1'b0;
            pad_ds_q   <= 1'b0;
            pad_pen_q  <= 1'b1;
            pad_ud_q   <= 1'b0;
            idle_cnt_q <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            pad_a_q    <= pad_a_d;
            pad_oen_q  <= pad_oen_d;
            pad_ds_q   <= pad_ds_d;
            pad_pen_q  <= pad_pen_d;
            pad_ud_q   <= pad_ud_d;
            idle_cnt_q <= idle_cnt_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign grant    = grant_q;
    assign pad_A    = pad_a_q;
    assign pad_OEN  = pad_oen_q;
    assign pad_DS   = pad_ds_q;
    assign pad_PEN  = pad_pen_q;
    assign pad_UD   = pad_ud_q;
    assign rx_valid = rx_valid_q;

    digio_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk (DCLK_1),
        .rst (rst),
        .d   (pad_Z),
        .q   (din_sync)
    );

`ifdef DIGIO_LOOPBACK_CHECK_EN
    logic [SYNC_STAGES-1:0] a_dly_q, a_dly_d;
    logic [IW-1:0]          drv_cnt_q, drv_cnt_d;
    logic                   err_q, err_d;
    logic                   mismatch;

    // a_dly tracks pad_A through the same depth as the receive synchronizer.
    always_comb begin
        a_dly_d   = {a_dly_q[SYNC_STAGES-2:0], pad_a_q};
        drv_cnt_d = '0;
        if (state_d == S_DRIVE && state_q == S_DRIVE)
            drv_cnt_d = (drv_cnt_q == IDLE_SAT) ? drv_cnt_q : drv_cnt_q + 1'b1;
        mismatch = (state_q == S_DRIVE) && (drv_cnt_q == IDLE_SAT) &&
                   (din_sync != a_dly_q[SYNC_STAGES-1]);
        err_d    = mismatch | (err_q & ~err_clr);
    end

    always_ff @(posedge DCLK_1 or posedge rst) begin
        if (rst) begin
            a_dly_q   <= '0;
            drv_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            a_dly_q   <= a_dly_d;
            drv_cnt_q <= drv_cnt_d;
            err_q     <= err_d;
        end
    end

    assign loopback_err = err_q;
`else
    logic err_clr_unused;
    assign err_clr_unused = err_clr;
    assign loopback_err   = 1'b0;
`endif

endmodule
